cpu_host_loader: RTL and testbench

Host-side initiator for the CPU's external memory ports. It streams a program from a valid/ready word input into instruction memory, then holds the CPU `enable` high for a programmed number of cycles. It then reads back a programmed number of data-memory words and emits them on a valid/ready output stream. It sits between the test/host interface and the `cpu` top, driving `addr_ext*`, `wen_ext*`, `ren_ext*`, `wdata_ext*` and `enable`, and consuming `rdata_ext_2`.

---
 rtl/cpu_host_loader.sv | 170 +++++++++++++++++
 tb/tb_cpu_host_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_host_loader.sv
// Host-side loader for the CPU's external memory ports: streams a program into
// instruction memory, runs the CPU for a fixed cycle count, then dumps data memory.
module cpu_host_loader #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned RUN_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [9:0]       prog_len,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic [10:0]      dump_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PL_W = 10;
  localparam int unsigned DL_W = 11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_DREQ, S_DWAIT, S_DOUT, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [PL_W-1:0]    r_prog_len;
  logic [DL_W-1:0]    r_dump_len;
  logic [PL_W-1:0]    r_load_cnt;
  logic [DL_W-1:0]    r_dump_cnt;
  logic [RUN_W-1:0]   r_run_cnt;
  logic               r_in_ready;
  logic               r_wen_ext;
  logic [63:0]        r_addr_ext;
  logic [31:0]        r_wdata_ext;
  logic               r_cpu_enable;
  logic               r_ren_ext_2;
  logic [63:0]        r_addr_ext_2;
  logic               r_out_valid;
  logic [63:0]        r_out_data;
  logic               r_busy;
  logic               r_done;

  logic [PL_W-1:0]    w_prog_clamp;
  logic [DL_W-1:0]    w_dump_clamp;
  logic               w_start_acc;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_load_last;
  logic               w_dump_last;
  logic [DL_W-1:0]    w_dump_idx;

  assign w_prog_clamp = (prog_len > PL_W'(IMEM_WORDS)) ? PL_W'(IMEM_WORDS) : prog_len;
  assign w_dump_clamp = (dump_len > DL_W'(DMEM_WORDS)) ? DL_W'(DMEM_WORDS) : dump_len;
  assign w_start_acc  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_in_hs      = (r_state == S_LOAD) && r_in_ready && in_valid;
  assign w_out_hs     = (r_state == S_DOUT) && r_out_valid && out_ready;
  assign w_load_last  = (r_load_cnt + PL_W'(1)) == r_prog_len;
  assign w_dump_last  = (r_dump_cnt + DL_W'(1)) == r_dump_len;
  // DREQ is only entered from DOUT for words after the first.
  assign w_dump_idx   = (r_state == S_DOUT) ? (r_dump_cnt + DL_W'(1)) : '0;

  // First active phase that still has work to do.
  function automatic state_t route(input logic p_nz, input logic r_nz, input logic d_nz);
    if (p_nz)      return S_LOAD;
    else if (r_nz) return S_RUN;
    else if (d_nz) return S_DREQ;
    else           return S_DONE;
  endfunction

  // Next-state decode
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_nxt = route(w_prog_clamp != '0, run_cycles != '0,
                                               w_dump_clamp != '0);
      S_LOAD:  if (w_in_hs && w_load_last) w_nxt = S_FLUSH;
      S_FLUSH: w_nxt = route(1'b0, r_run_cnt != '0, r_dump_len != '0);
      S_RUN:   if (r_run_cnt <= RUN_W'(1)) w_nxt = route(1'b0, 1'b0, r_dump_len != '0);
      S_DREQ:  w_nxt = S_DWAIT;
      S_DWAIT: w_nxt = S_DOUT;
      S_DOUT:  if (w_out_hs) w_nxt = w_dump_last ? S_DONE : S_DREQ;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, counters and registered strobes
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= S_IDLE;
      r_prog_len   <= '0;
      r_dump_len   <= '0;
      r_load_cnt   <= '0;
      r_dump_cnt   <= '0;
      r_run_cnt    <= '0;
      r_in_ready   <= 1'b0;
      r_wen_ext    <= 1'b0;
      r_addr_ext   <= '0;
      r_wdata_ext  <= '0;
      r_cpu_enable <= 1'b0;
      r_ren_ext_2  <= 1'b0;
      r_addr_ext_2 <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_in_ready   <= (w_nxt == S_LOAD);
      r_cpu_enable <= (w_nxt == S_RUN);
      r_ren_ext_2  <= (w_nxt == S_DREQ);
      r_out_valid  <= (w_nxt == S_DOUT);
      r_busy       <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
      r_done       <= (w_nxt == S_DONE);
      r_wen_ext    <= w_in_hs;

      if (w_start_acc) begin
        r_prog_len <= w_prog_clamp;
        r_dump_len <= w_dump_clamp;
        r_run_cnt  <= run_cycles;
        r_load_cnt <= '0;
        r_dump_cnt <= '0;
      end

      if (w_in_hs) begin
        r_addr_ext  <= 64'({r_load_cnt, 2'b00});
        r_wdata_ext <= in_data;
        r_load_cnt  <= r_load_cnt + PL_W'(1);
      end

      if ((r_state == S_RUN) && (r_run_cnt != '0)) r_run_cnt <= r_run_cnt - RUN_W'(1);

      if (w_nxt == S_DREQ) r_addr_ext_2 <= 64'({w_dump_idx, 3'b000});
      if (r_state == S_DWAIT) r_out_data <= rdata_ext_2;
      if (w_out_hs) r_dump_cnt <= r_dump_cnt + DL_W'(1);
    end
  end

  assign in_ready    = r_in_ready;
  assign addr_ext    = r_addr_ext;
  assign wen_ext     = r_wen_ext;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata_ext;
  assign cpu_enable  = r_cpu_enable;
  assign addr_ext_2  = r_addr_ext_2;
  assign wen_ext_2   = 1'b0;
  assign ren_ext_2   = r_ren_ext_2;
  assign wdata_ext_2 = '0;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_cpu_host_loader.sv
// Bench for cpu_host_loader: emulates data memory, records every strobe and checks
// session timelines derived from the load/run/dump rules.
module tb_cpu_host_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  prog_len = '0;
  logic [31:0] run_cycles = '0;
  logic [10:0] dump_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic        cpu_enable;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;
  logic        done;

  cpu_host_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start), .prog_len(prog_len),
    .run_cycles(run_cycles), .dump_len(dump_len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .addr_ext(addr_ext), .wen_ext(wen_ext),
    .ren_ext(ren_ext), .wdata_ext(wdata_ext), .cpu_enable(cpu_enable),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] dmem [1024];
  logic [31:0] words [512];

  // Data memory behaves like the CPU's: read data valid the cycle after ren.
  always @(posedge clk) rdata_ext_2 <= ren_ext_2 ? dmem[addr_ext_2[12:3]] : {$urandom, $urandom};

  task automatic check_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int          wr_cyc[$];
  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          hs_cyc[$];
  int          en_cyc[$];
  int          rd_cyc[$];
  logic [63:0] rd_addr[$];
  int          rise_cyc[$];
  int          oh_cyc[$];
  logic [63:0] oh_data[$];
  logic        prev_stall = 1'b0;
  logic        prev_ov = 1'b0;
  logic [63:0] prev_od = '0;

  // Strobe recorder plus output hold-under-backpressure check
  always @(negedge clk) begin
    if (!arst_n) begin
      prev_stall = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (prev_stall) begin
        check_i("hold_valid", int'(out_valid), 1);
        check_v("hold_data", out_data, prev_od);
      end
      if (wen_ext) begin wr_cyc.push_back(cyc); wr_addr.push_back(addr_ext); wr_data.push_back(wdata_ext); end
      if (in_valid && in_ready) hs_cyc.push_back(cyc);
      if (cpu_enable) en_cyc.push_back(cyc);
      if (ren_ext_2) begin rd_cyc.push_back(cyc); rd_addr.push_back(addr_ext_2); end
      if (out_valid && !prev_ov) rise_cyc.push_back(cyc);
      if (out_valid && out_ready) begin oh_cyc.push_back(cyc); oh_data.push_back(out_data); end
      prev_stall = out_valid && !out_ready;
      prev_ov = out_valid;
      prev_od = out_data;
    end
  end

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); hs_cyc.delete();
    en_cyc.delete(); rd_cyc.delete(); rd_addr.delete(); rise_cyc.delete();
    oh_cyc.delete(); oh_data.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_v({tag, "_addr_ext"}, addr_ext, 64'd0);
    check_v({tag, "_addr_ext_2"}, addr_ext_2, 64'd0);
    check_v({tag, "_out_data"}, out_data, 64'd0);
    check_v({tag, "_wdata_ext"}, 64'(wdata_ext), 64'd0);
    check_v({tag, "_strobes"}, 64'({in_ready, wen_ext, ren_ext, cpu_enable, wen_ext_2,
                                   ren_ext_2, out_valid, busy, done}), 64'd0);
    check_v({tag, "_wdata_ext_2"}, wdata_ext_2, 64'd0);
  endtask

  task automatic fill_words();
    for (int i = 0; i < 512; i++) words[i] = $urandom;
  endtask

  // vmode: 0 in_valid held high, 1 random. omode: 0 ready high, 1 random, 2 pattern 1,0,0,1.
  task automatic session(input int p, input int r, input int d, input int vmode,
                         input int omode, input bit glitch);
    int pe, de, s, widx, done_c, busy_n, pat, t, exp_done;
    bit hs, done_seen, gl_done;
    pe = (p > 512) ? 512 : p;
    de = (d > 1024) ? 1024 : d;
    clear_logs();
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1; prog_len = 10'(p); run_cycles = 32'(r); dump_len = 11'(d);
    widx = 0; done_seen = 0; busy_n = 0; pat = 1; gl_done = 0; done_c = 0;
    in_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    in_data = words[0];
    out_ready = (omode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 20000 && !done_seen; c++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      if (cyc > s) begin
        if (done) begin
          done_seen = 1; done_c = cyc;
          check_i("busy_at_done", int'(busy), 0);
        end else if (busy) busy_n++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) widx++;
      if (glitch && !gl_done && widx == 1) begin
        start = 1'b1; prog_len = 10'(p + 3); gl_done = 1;
      end
      in_data = (widx < pe) ? words[widx] : $urandom;
      in_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (omode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
      endcase
      pat++;
    end
    check_i("done_reached", int'(done_seen), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b0;

    check_i("n_handshakes", hs_cyc.size(), pe);
    check_i("n_writes", wr_cyc.size(), pe);
    if (pe > 0 && vmode == 0 && hs_cyc.size() > 0) check_i("in_ready_latency", hs_cyc[0], s + 1);
    for (int k = 0; k < pe && k < wr_cyc.size() && k < hs_cyc.size(); k++) begin
      check_v("wr_addr", wr_addr[k], 64'(4 * k));
      check_v("wr_data", 64'(wr_data[k]), 64'(words[k]));
      check_i("wr_latency", wr_cyc[k], hs_cyc[k] + 1);
    end
    t = s + 1;
    if (pe > 0 && hs_cyc.size() >= pe) t = hs_cyc[pe-1] + 2;
    check_i("n_enable", en_cyc.size(), r);
    if (r > 0 && en_cyc.size() > 0) begin
      check_i("en_first", en_cyc[0], t);
      check_i("en_last", en_cyc[en_cyc.size()-1], t + r - 1);
    end
    t = t + r;
    check_i("n_reads", rd_cyc.size(), de);
    check_i("n_outs", oh_cyc.size(), de);
    for (int j = 0; j < de && j < rd_cyc.size() && j < oh_cyc.size() && j < rise_cyc.size(); j++) begin
      check_v("rd_addr", rd_addr[j], 64'(8 * j));
      check_i("rd_cycle", rd_cyc[j], (j == 0) ? t : oh_cyc[j-1] + 1);
      check_i("valid_rise", rise_cyc[j], rd_cyc[j] + 2);
      check_v("out_data", oh_data[j], dmem[j]);
      if (omode == 0) check_i("out_rate", oh_cyc[j], rd_cyc[j] + 2);
    end
    exp_done = (de > 0 && oh_cyc.size() >= de) ? oh_cyc[de-1] + 1 : t;
    check_i("done_cycle", done_c, exp_done);
    check_i("busy_span", busy_n, done_c - s - 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = {$urandom, $urandom};
    fill_words();
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Directed program, 20 run cycles, stalled dump
    words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0000_0063;
    session(3, 20, 4, 0, 2, 1'b0);
    check_i("done_level", int'(done), 1);

    // Empty session from DONE
    session(0, 0, 0, 0, 0, 1'b0);

    // Start while loading is ignored
    fill_words();
    session(5, 4, 2, 1, 0, 1'b1);

    // Reset mid-RUN then replay
    fill_words();
    @(posedge clk); #1;
    start = 1'b1; prog_len = 10'd1; run_cycles = 32'd30; dump_len = 11'd2;
    in_valid = 1'b1; in_data = words[0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && !cpu_enable; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_i("en_before_rst", int'(cpu_enable), 1);
    #2 arst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    in_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    session(3, 5, 3, 1, 1, 1'b0);

    // Length clamping
    fill_words();
    session(700, 2, 1500, 1, 0, 1'b0);

    // Randomised sessions
    for (int it = 0; it < 8; it++) begin
      fill_words();
      session($urandom_range(0, 20), $urandom_range(0, 40), $urandom_range(0, 12),
              $urandom_range(0, 1), $urandom_range(0, 2), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
